// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
// rom_load_ctrl
//   Sequences HPS ioctl downloads into the BIOS (index 0) and cart (index 1)
//   dpram images. Registers every write, tracks the loaded cart size, pads the
//   unloaded cart tail with FILL_BYTE and holds the console in reset until
//   loading, padding and a settle delay have finished.
//
// Ports
//   clk_sys, reset_n      clock, asynchronous active-low reset
//   ioctl_download        download in progress (level)
//   ioctl_index           download target: 0 = BIOS, 1 = cart, others ignored
//   ioctl_wr              one-cycle byte strobe
//   ioctl_addr/dout       byte address within the file / byte data
//   mem_addr/mem_data     shared dpram write address / data
//   bios_we/cart_we       per-image write enables (never high together)
//   cart_size             highest cart byte written + 1 (0 = no cart)
//   overflow              sticky: an out-of-image write was dropped this load
//   busy                  high in every state except IDLE
//   cpu_reset             console reset request
module rom_load_ctrl #(
    parameter int unsigned AW          = 13,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          bios_we,
    output logic          cart_we,
    output logic [15:0]   cart_size,
    output logic          overflow,
    output logic          busy,
    output logic          cpu_reset
);

    localparam int unsigned DEPTH = 32'd1 << AW;
    localparam int unsigned HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [AW-1:0] fill_ptr_q, fill_ptr_d;
    logic          cart_idx_q, cart_idx_d;
    logic          dl_q;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_data_q, mem_data_d;
    logic          bios_we_q, bios_we_d;
    logic          cart_we_q, cart_we_d;
    logic [15:0]   cart_size_q, cart_size_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, cpu_reset_q;
    logic          run_d;

    logic          dl_rise, dl_fall, idx_ok, start, load_en, cur_cart, in_range;
    logic [15:0]   addr_p1;

    // Download edge detection and write qualification
    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign idx_ok   = (ioctl_index == 8'd0) || (ioctl_index == 8'd1);
    assign start    = dl_rise & idx_ok;
    // A write in the cycle a download starts belongs to that new download
    assign load_en  = start | (state_q == S_LOAD);
    assign cur_cart = start ? ioctl_index[0] : cart_idx_q;
    assign in_range = (ioctl_addr >> AW) == 25'd0;
    assign addr_p1  = 16'(ioctl_addr[AW-1:0]) + 16'd1;
    assign run_d    = (state_d != S_IDLE);

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            fill_ptr_q  <= '0;
            cart_idx_q  <= 1'b0;
            dl_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            bios_we_q   <= 1'b0;
            cart_we_q   <= 1'b0;
            cart_size_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            fill_ptr_q  <= fill_ptr_d;
            cart_idx_q  <= cart_idx_d;
            dl_q        <= ioctl_download;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            bios_we_q   <= bios_we_d;
            cart_we_q   <= cart_we_d;
            cart_size_q <= cart_size_d;
            overflow_q  <= overflow_d;
            busy_q      <= run_d;
            cpu_reset_q <= run_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        fill_ptr_d = fill_ptr_q;
        cart_idx_d = cart_idx_q;
        if (start) begin
            // A new valid download abandons whatever was in progress
            state_d    = S_LOAD;
            cart_idx_d = ioctl_index[0];
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (dl_fall) begin
                        // cart_size_d already includes a write accepted this cycle
                        if (cart_idx_q && (32'(cart_size_d) < DEPTH)) begin
                            state_d    = S_FILL;
                            fill_ptr_d = cart_size_d[AW-1:0];
                        end else begin
                            state_d    = S_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                S_FILL: begin
                    fill_ptr_d = fill_ptr_q + AW'(1);
                    if (&fill_ptr_q) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        bios_we_d   = 1'b0;
        cart_we_d   = 1'b0;
        cart_size_d = cart_size_q;
        overflow_d  = overflow_q;
        if (start) begin
            overflow_d = 1'b0;
            if (ioctl_index[0]) begin
                cart_size_d = '0;
            end
        end
        if (load_en && ioctl_wr) begin
            if (in_range) begin
                mem_addr_d = ioctl_addr[AW-1:0];
                mem_data_d = ioctl_dout;
                bios_we_d  = ~cur_cart;
                cart_we_d  = cur_cart;
                if (cur_cart && (addr_p1 > cart_size_d)) begin
                    cart_size_d = addr_p1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end else if ((state_q == S_FILL) && !start) begin
            mem_addr_d = fill_ptr_q;
            mem_data_d = FILL_BYTE;
            cart_we_d  = 1'b1;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign bios_we   = bios_we_q;
    assign cart_we   = cart_we_q;
    assign cart_size = cart_size_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// tb_rom_load_ctrl
//   Table of download scenarios plus hand-written corner sequences.
//   Expected dpram writes are queued when driven and popped as they appear.
module tb_rom_load_ctrl;

    localparam int AW    = 13;
    localparam int DEPTH = 8192;
    localparam int FILLV = 8'hFF;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          bios_we;
    logic          cart_we;
    logic [15:0]   cart_size;
    logic          overflow;
    logic          busy;
    logic          cpu_reset;

    rom_load_ctrl #(.AW(13), .FILL_BYTE(8'hFF), .HOLD_CYCLES(16)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .bios_we        (bios_we),
        .cart_we        (cart_we),
        .cart_size      (cart_size),
        .overflow       (overflow),
        .busy           (busy),
        .cpu_reset      (cpu_reset)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        bit cart;
        int addr;
        int data;
        int cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0] idx;
        int         base;
        int         count;
        int         sp0;        // extra write address, -1 = none
        int         sp1;
        bit         last_fall;  // last extra write shares its cycle with the download fall
        int         exp_size;
        bit         exp_ovf;
        int         exp_fill;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int dat(input int a, input int idx);
        return (a * 7 + idx * 31 + 3) & 255;
    endfunction

    // Write monitor: every enable pulse must match the head of the queue
    always @(negedge clk_sys) begin
        if (reset_n && (bios_we || cart_we)) begin
            if (bios_we && cart_we) begin
                nchk++;
                nfail++;
                $display("FAIL both_we: bios_we=1 cart_we=1 at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_we: cart=%0d addr=%0d data=%0d cycle=%0d, none expected",
                         cart_we, mem_addr, mem_data, cyc);
            end else begin
                sb_t e;
                e = sb.pop_front();
                nchk++;
                if (e.cart != cart_we || e.addr != int'(mem_addr) ||
                    e.data != int'(mem_data) || e.cyc != cyc) begin
                    nfail++;
                    $display("FAIL write: got cart=%0d addr=%0d data=%0d cycle=%0d expected cart=%0d addr=%0d data=%0d cycle=%0d",
                             cart_we, mem_addr, mem_data, cyc, e.cart, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        ioctl_index    = idx;
    endtask

    task automatic drive_wr(input int addr, input int data, input bit cart, input bit push,
                            input bit with_fall, output int fall_cyc);
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = 8'(data);
        if (with_fall) ioctl_download = 1'b0;
        fall_cyc = cyc;
        if (push && addr < DEPTH) sb.push_back('{cart, addr, data, cyc + 1});
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic drop_dl(output int c);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        c = cyc;
    endtask

    task automatic push_fill(input int first, input int n, input int c);
        for (int i = 0; i < n; i++) sb.push_back('{1'b1, first + i, FILLV, c + 2 + i});
    endtask

    task automatic wait_release(input string name, input int exp);
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk_sys);
            if (!cpu_reset) done = 1'b1;
        end
        if (!done) begin
            nchk++;
            nfail++;
            $display("FAIL %s: cpu_reset still high after timeout, expected fall at cycle %0d", name, exp);
        end else begin
            chk(name, cyc, exp);
        end
    endtask

    initial begin
        int c, r, s;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        reset_n        = 1'b1;

        vecs[0] = '{8'd0, 0,    8192, -1,   -1,   1'b0, 0,    1'b0, 0};     // full BIOS
        vecs[1] = '{8'd1, 0,    4096, -1,   -1,   1'b0, 4096, 1'b0, 4096};  // half cart + pad
        vecs[2] = '{8'd1, 0,    0,    9000, 8190, 1'b1, 8191, 1'b1, 1};     // drop + pending write
        vecs[3] = '{8'd0, 100,  16,   9000, -1,   1'b0, 8191, 1'b1, 0};     // BIOS keeps cart_size
        vecs[4] = '{8'd1, 0,    0,    8191, -1,   1'b0, 8192, 1'b0, 0};     // cart exactly full
        vecs[5] = '{8'd1, 8000, 10,   8005, -1,   1'b0, 8010, 1'b0, 182};   // lower addr keeps max

        // Reset values and release timing
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_mem_addr",  int'(mem_addr),  0);
        chk("rst_mem_data",  int'(mem_data),  0);
        chk("rst_bios_we",   int'(bios_we),   0);
        chk("rst_cart_we",   int'(cart_we),   0);
        chk("rst_cart_size", int'(cart_size), 0);
        chk("rst_overflow",  int'(overflow),  0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_cpu_reset", int'(cpu_reset), 1);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        r = cyc;
        wait_release("por_release", r + 16);
        chk("por_busy", int'(busy), 0);

        // Table-driven downloads
        foreach (vecs[k]) begin
            bit cart;
            c = 0;
            cart = (vecs[k].idx == 8'd1);
            start_dl(vecs[k].idx);
            for (int i = 0; i < vecs[k].count; i++)
                drive_wr(vecs[k].base + i, dat(vecs[k].base + i, k), cart, 1'b1, 1'b0, c);
            if (vecs[k].sp0 >= 0)
                drive_wr(vecs[k].sp0, dat(vecs[k].sp0, k), cart, 1'b1,
                         vecs[k].last_fall && (vecs[k].sp1 < 0), c);
            if (vecs[k].sp1 >= 0)
                drive_wr(vecs[k].sp1, dat(vecs[k].sp1, k), cart, 1'b1, vecs[k].last_fall, c);
            if (!vecs[k].last_fall) drop_dl(c);
            push_fill(DEPTH - vecs[k].exp_fill, vecs[k].exp_fill, c);
            wait_release($sformatf("v%0d_release", k), c + 17 + vecs[k].exp_fill);
            chk($sformatf("v%0d_cart_size", k), int'(cart_size), vecs[k].exp_size);
            chk($sformatf("v%0d_overflow", k),  int'(overflow),  int'(vecs[k].exp_ovf));
            chk($sformatf("v%0d_busy", k),      int'(busy),      0);
            chk($sformatf("v%0d_sb_empty", k),  sb.size(),       0);
        end

        // New cart download started in the middle of FILL
        start_dl(8'd1);
        drive_wr(0, dat(0, 9), 1'b1, 1'b1, 1'b0, c);
        drive_wr(1, dat(1, 9), 1'b1, 1'b1, 1'b0, c);
        drop_dl(c);
        push_fill(2, 100, c);
        s = c + 101;
        while (cyc < s) begin
            @(posedge clk_sys); #1;
        end
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("restart_cart_size", int'(cart_size), 0);
        chk("restart_busy",      int'(busy),      1);
        chk("restart_cpu_reset", int'(cpu_reset), 1);
        repeat (20) @(negedge clk_sys);
        chk("restart_no_fill", sb.size(), 0);
        for (int i = 0; i < 8; i++) drive_wr(8000 + i, dat(8000 + i, 10), 1'b1, 1'b1, 1'b0, c);
        drop_dl(c);
        push_fill(8008, 184, c);
        wait_release("restart_release", c + 17 + 184);
        chk("restart_final_size", int'(cart_size), 8008);
        chk("restart_sb_empty",   sb.size(),       0);

        // Ignored index
        start_dl(8'd2);
        drive_wr(5, 77, 1'b0, 1'b0, 1'b0, c);
        drive_wr(6, 78, 1'b1, 1'b0, 1'b0, c);
        @(negedge clk_sys);
        chk("idx2_busy_during", int'(busy), 0);
        drop_dl(c);
        repeat (3) @(negedge clk_sys);
        chk("idx2_busy_after",   int'(busy),      0);
        chk("idx2_cpu_reset",    int'(cpu_reset), 0);
        chk("idx2_cart_size",    int'(cart_size), 8008);

        // Reset pulsed mid-LOAD with a write on the outputs
        start_dl(8'd0);
        drive_wr(10, dat(10, 11), 1'b0, 1'b1, 1'b0, c);
        drive_wr(11, dat(11, 11), 1'b0, 1'b1, 1'b0, c);
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd12;
        ioctl_dout = 8'd99;
        @(posedge clk_sys); #3;
        reset_n        = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("mid_rst_mem_addr",  int'(mem_addr),  0);
        chk("mid_rst_mem_data",  int'(mem_data),  0);
        chk("mid_rst_bios_we",   int'(bios_we),   0);
        chk("mid_rst_cart_size", int'(cart_size), 0);
        chk("mid_rst_busy",      int'(busy),      0);
        chk("mid_rst_cpu_reset", int'(cpu_reset), 1);
        repeat (3) @(negedge clk_sys);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        r = cyc;
        wait_release("mid_rst_release", r + 16);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
